// File: rtl/instr_mem_loader_if.sv
// Byte-stream and instruction-memory write bus for the instruction loader.
// slave: the loader (consumes bytes, drives the write strobe).
// master: the debug unit / memory side.
interface instr_mem_loader_if #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) ();
  logic               i_byte_valid;
  logic [NB_BYTE-1:0] i_byte;
  logic               o_byte_ready;
  logic               o_we;
  logic [NB_DATA-1:0] o_instr_data;

  modport slave  (input  i_byte_valid, i_byte,
                  output o_byte_ready, o_we, o_instr_data);
  modport master (output i_byte_valid, i_byte,
                  input  o_byte_ready, o_we, o_instr_data);
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: assembles big-endian words from a byte stream
// and writes them into instruction memory until HALT_WORD or memory full.
module instr_mem_loader #(
  parameter int                 NB_DATA   = 32,
  parameter int                 NB_BYTE   = 8,
  parameter int                 MEM_DEPTH = 64,
  parameter logic [NB_DATA-1:0] HALT_WORD = '1,
  localparam int                NB_CNT    = $clog2(MEM_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  instr_mem_loader_if.slave    bus,
  output logic [NB_CNT-1:0]    o_word_count,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overflow
);
  localparam int BPW   = NB_DATA / NB_BYTE;
  localparam int NB_BC = $clog2(BPW);
  localparam int NB_SH = NB_DATA - NB_BYTE;
  localparam logic [NB_BC-1:0]  LAST_BC = NB_BC'(BPW - 1);
  localparam logic [NB_CNT-1:0] FULL    = NB_CNT'(MEM_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WRITE, ST_DONE} state_t;

  state_t             state_q;
  logic [NB_BC-1:0]   bcnt_q;
  logic [NB_SH-1:0]   shreg_q;
  logic [NB_DATA-1:0] data_q;
  logic [NB_CNT-1:0]  cnt_q;
  logic               we_q, ready_q, busy_q, done_q, ovf_q;

  logic [NB_DATA-1:0] word_d;
  logic [NB_CNT-1:0]  cnt_d;

  // Word as it would look with the current byte shifted in; count after a write
  assign word_d = {shreg_q, bus.i_byte};
  assign cnt_d  = cnt_q + NB_CNT'(1);

  // Abort must kill the strobe and the handshake in the very cycle it is seen
  assign bus.o_we         = we_q & ~i_abort;
  assign bus.o_byte_ready = ready_q & ~i_abort;
  assign bus.o_instr_data = data_q;
  assign o_word_count     = cnt_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;
  assign o_overflow       = ovf_q;

  // Session FSM with registered outputs
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        // IDLE and DONE behave alike: only i_start matters, abort is ignored
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            bcnt_q  <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (i_abort) begin
            state_q <= ST_IDLE;
            bcnt_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (bus.i_byte_valid) begin
            shreg_q <= word_d[NB_SH-1:0];
            if (bcnt_q == LAST_BC) begin
              state_q <= ST_WRITE;
              data_q  <= word_d;
              we_q    <= 1'b1;
              ready_q <= 1'b0;
              bcnt_q  <= '0;
            end else begin
              bcnt_q  <= bcnt_q + NB_BC'(1);
            end
          end
        end
        // The strobe is out this cycle; the count commits at its end unless aborted
        ST_WRITE: begin
          we_q <= 1'b0;
          if (i_abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
            if (data_q == HALT_WORD) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (cnt_d == FULL) begin
              state_q <= ST_DONE;
              ovf_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_LOAD;
              ready_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, start4 = 1'b0, abort4 = 1'b0;
  logic [6:0] cnt;
  logic [2:0] cnt4;
  logic busy, done, ovf, busy4, done4, ovf4;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] wq[$];
  logic [31:0] wq4[$];

  always #5 clk = ~clk;

  instr_mem_loader_if #(.NB_DATA(32), .NB_BYTE(8)) bus ();
  instr_mem_loader_if #(.NB_DATA(32), .NB_BYTE(8)) bus4 ();

  instr_mem_loader #(.MEM_DEPTH(64)) dut (
    .clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .bus(bus),
    .o_word_count(cnt), .o_busy(busy), .o_done(done), .o_overflow(ovf));

  instr_mem_loader #(.MEM_DEPTH(4)) dut4 (
    .clk(clk), .i_rst(rst), .i_start(start4), .i_abort(abort4), .bus(bus4),
    .o_word_count(cnt4), .o_busy(busy4), .o_done(done4), .o_overflow(ovf4));

  // Record every write strobe seen by memory
  always @(negedge clk) begin
    if (bus.o_we)  wq.push_back(bus.o_instr_data);
    if (bus4.o_we) wq4.push_back(bus4.o_instr_data);
  end

  typedef struct {
    logic start, abort, valid;
    logic [7:0] b;
    logic ready, we;
    logic [31:0] data;
    logic [6:0] cnt;
    logic busy, done, ovf;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic s, logic a, logic v, logic [7:0] b, logic r, logic w,
                              logic [31:0] d, logic [6:0] c, logic bs, logic dn, logic ov);
    vec_t t;
    t.start = s; t.abort = a; t.valid = v; t.b = b; t.ready = r; t.we = w;
    t.data = d; t.cnt = c; t.busy = bs; t.done = dn; t.ovf = ov;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {20'd0, bus.o_byte_ready, bus.o_we, bus.o_instr_data, cnt, busy, done, ovf};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_in(input int sel, input logic v, input logic [7:0] b);
    if (sel == 0) begin bus.i_byte_valid = v; bus.i_byte = b; end
    else begin bus4.i_byte_valid = v; bus4.i_byte = b; end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? bus.o_byte_ready : bus4.o_byte_ready;
  endfunction

  // Present a byte and hold it until accepted or the cycle budget runs out
  task automatic send_byte(input int sel, input logic [7:0] b, input int idle,
                           input int limit, output bit got);
    got = 1'b0;
    set_in(sel, 1'b0, 8'h00);
    repeat (idle) tick();
    set_in(sel, 1'b1, b);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rdy(sel)) begin got = 1'b1; break; end
      if (i < limit - 1) begin @(posedge clk); #1; end
    end
    tick();
    set_in(sel, 1'b0, 8'h00);
  endtask

  task automatic send_word(input int sel, input logic [31:0] w, input int idle);
    bit got;
    for (int k = 0; k < 4; k++) begin
      send_byte(sel, w[31-8*k -: 8], idle, 20, got);
      chk("byte_accept", 64'(got), 64'd1);
    end
  endtask

  task automatic pulse_start(input int sel);
    if (sel == 0) start = 1'b1; else start4 = 1'b1;
    tick();
    start = 1'b0; start4 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wq.delete();
    wq4.delete();
  endtask

  initial begin
    bit got;
    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    do_reset();

    // Test 1: table-driven cycle-by-cycle (outputs are those seen while inputs apply)
    //              st ab vl byte  rdy we data          cnt busy done ovf
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 32'h00000000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h88, 1, 0, 32'h00000000, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h88, 1, 0, 32'h00000000, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h88, 1, 0, 32'h00000000, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h88, 1, 0, 32'h00000000, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 32'h88888888, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'hFF, 1, 0, 32'h88888888, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'hFF, 1, 0, 32'h88888888, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'hFF, 1, 0, 32'h88888888, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'hFF, 1, 0, 32'h88888888, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 32'hFFFFFFFF, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 32'hFFFFFFFF, 2, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 8'h55, 0, 0, 32'hFFFFFFFF, 2, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 32'hFFFFFFFF, 2, 0, 1, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].start; abort = tbl[i].abort;
      set_in(0, tbl[i].valid, tbl[i].b);
      @(negedge clk);
      chk($sformatf("t1_vec%0d", i), outs(),
          {20'd0, tbl[i].ready, tbl[i].we, tbl[i].data, tbl[i].cnt,
           tbl[i].busy, tbl[i].done, tbl[i].ovf});
      tick();
    end
    start = 1'b0; abort = 1'b0; set_in(0, 1'b0, 8'h00);

    // Test 2: gapped stream, embedded FF bytes do not halt
    do_reset();
    pulse_start(0);
    send_word(0, 32'hA8A8A8A8, 1);
    send_word(0, 32'hAAAAAAAA, 1);
    send_word(0, 32'h0000FFFF, 1);
    send_word(0, 32'hFFFFFFFF, 1);
    repeat (3) tick();
    chk("t2_nwr", 64'(wq.size()), 64'd4);
    if (wq.size() == 4) begin
      chk("t2_w0", 64'(wq[0]), 64'hA8A8A8A8);
      chk("t2_w1", 64'(wq[1]), 64'hAAAAAAAA);
      chk("t2_w2", 64'(wq[2]), 64'h0000FFFF);
      chk("t2_w3", 64'(wq[3]), 64'hFFFFFFFF);
    end
    chk("t2_state", {cnt, busy, done, ovf}, {7'd4, 1'b0, 1'b1, 1'b0});

    // Test 3: MEM_DEPTH=4 overflow, fifth word refused
    do_reset();
    pulse_start(1);
    for (int w = 1; w <= 4; w++) send_word(1, 32'(w), 0);
    repeat (2) tick();
    send_byte(1, 8'h00, 0, 8, got);
    chk("t3_refused", 64'(got), 64'd0);
    chk("t3_nwr", 64'(wq4.size()), 64'd4);
    if (wq4.size() == 4) chk("t3_last", 64'(wq4[3]), 64'd4);
    chk("t3_state", {bus4.o_byte_ready, cnt4, busy4, done4, ovf4},
        {1'b0, 3'd4, 1'b0, 1'b0, 1'b1});

    // Test 3b: HALT as the MEM_DEPTH-th word -> done, not overflow
    do_reset();
    pulse_start(1);
    for (int w = 1; w <= 3; w++) send_word(1, 32'(w), 0);
    send_word(1, 32'hFFFFFFFF, 0);
    repeat (2) tick();
    chk("t3b_state", {cnt4, busy4, done4, ovf4}, {3'd4, 1'b0, 1'b1, 1'b0});

    // Test 4: abort during LOAD keeps the prefix count, drops partial word
    do_reset();
    pulse_start(0);
    send_word(0, 32'h01020304, 0);
    send_byte(0, 8'h12, 0, 20, got);
    send_byte(0, 8'h34, 0, 20, got);
    abort = 1'b1;
    @(negedge clk);
    chk("t4_abort_rdy", 64'(bus.o_byte_ready), 64'd0);
    tick();
    abort = 1'b0;
    repeat (2) tick();
    chk("t4_after_abort", {bus.o_byte_ready, cnt, busy, done, ovf, 8'(wq.size())},
        {1'b0, 7'd1, 1'b0, 1'b0, 1'b0, 8'd1});
    pulse_start(0);
    chk("t4_cnt_clr", 64'(cnt), 64'd0);
    send_word(0, 32'h12345678, 0);
    tick();
    chk("t4_nwr", 64'(wq.size()), 64'd2);
    chk("t4_word", 64'(wq[$]), 64'h12345678);
    chk("t4_cnt", 64'(cnt), 64'd1);

    // Test 4b: abort in the WRITE cycle suppresses the strobe and the count
    send_word(0, 32'hAABBCCDD, 0);
    abort = 1'b1;
    @(negedge clk);
    chk("t4b_we_gated", 64'(bus.o_we), 64'd0);
    tick();
    abort = 1'b0;
    chk("t4b_state", {cnt, busy, 8'(wq.size())}, {7'd1, 1'b0, 8'd2});

    // Test 5: reset mid-word clears everything; stale byte waits for start
    pulse_start(0);
    send_byte(0, 8'h11, 0, 20, got);
    send_byte(0, 8'h22, 0, 20, got);
    send_byte(0, 8'h33, 0, 20, got);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_reset_outs", outs(), 64'd0);
    tick();
    send_byte(0, 8'h44, 0, 6, got);
    chk("t5_no_accept", 64'(got), 64'd0);
    chk("t5_no_we", 64'(wq.size()), 64'd2);
    pulse_start(0);
    send_word(0, 32'h44556677, 0);
    tick();
    chk("t5_word", 64'(wq[$]), 64'h44556677);
    chk("t5_cnt", 64'(cnt), 64'd1);

    // Test 6: start pulse while busy is ignored
    send_byte(0, 8'h9A, 0, 20, got);
    send_byte(0, 8'hBC, 0, 20, got);
    pulse_start(0);
    chk("t6_cnt_kept", {cnt, busy}, {7'd1, 1'b1});
    send_byte(0, 8'hDE, 0, 20, got);
    send_byte(0, 8'hF0, 0, 20, got);
    tick();
    chk("t6_word", 64'(wq[$]), 64'h9ABCDEF0);
    chk("t6_cnt", {cnt, busy, done}, {7'd2, 1'b1, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
